lcd_bus_arbiter: RTL and testbench



---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_rr_arb.sv | 27 ++
 rtl/lcd_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the LCD bus arbiter and its clients: the init
// sequencer and the text writer.
// Contents:
//   lcd_state_t        - bus-cycle states of the arbiter FSM
//   DEF_*              - default timing constants in clk cycles at 50 MHz
//   last_count()       - converts a duration into the terminal value of a
//                        0-based up-counter
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_EN_HIGH = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DONE    = 3'd4
  } lcd_state_t;

  localparam int unsigned DEF_RS_SETUP   = 2;
  localparam int unsigned DEF_EN_PULSE   = 50;
  localparam int unsigned DEF_CMD_DELAY  = 250_000;  // 5 ms at 50 MHz
  localparam int unsigned DEF_CHAR_DELAY = 2_500;    // 50 us at 50 MHz

  // A phase of N cycles ends when a counter that started at 0 reads N-1.
  function automatic logic [31:0] last_count(input int unsigned cycles);
    return 32'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// lcd_rr_arb
// Two-requester round-robin grant logic. This block is purely
// combinational. The caller stores the last-granted flag and updates it
// when a grant is taken.
// Ports:
//   req   [1:0] in  - request vector, bit 0 = port 0, bit 1 = port 1
//   last        in  - port granted most recently (0 = port 0, 1 = port 1)
//   grant [1:0] out - one-hot grant, all zero when nothing is requested
module lcd_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // A lone request always wins. On a tie, the port that was not served
  // last time gets the grant.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter
// Shares one HD44780-style LCD bus between two writers. Each writer is
// port 0 (the init sequencer) or port 1 (the text writer). A granted byte
// is driven with the following timing:
//   1. RS/DATA setup.
//   2. An EN pulse.
//   3. A post-pulse wait, whose length depends on RS.
// The owning port then gets a single-cycle ack.
// Ports:
//   clk, rst              - clock; asynchronous active-low reset
//   req0/1, rs0/1, data0/1 - per-port request, register select, byte
//   ack0/1                - one-cycle completion pulse for the owning port
//   busy                  - high from the grant edge to the end of DONE
//   LCD_DATA/RS/RW/EN     - LCD bus pins (RW is always write)
//   LCD_ON, LCD_BLON      - panel power and backlight enables
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned RS_SETUP   = DEF_RS_SETUP,
  parameter int unsigned EN_PULSE   = DEF_EN_PULSE,
  parameter int unsigned CMD_DELAY  = DEF_CMD_DELAY,
  parameter int unsigned CHAR_DELAY = DEF_CHAR_DELAY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  localparam logic [31:0] SETUP_LAST = last_count(RS_SETUP);
  localparam logic [31:0] PULSE_LAST = last_count(EN_PULSE);
  localparam logic [31:0] CMD_LAST   = last_count(CMD_DELAY);
  localparam logic [31:0] CHAR_LAST  = last_count(CHAR_DELAY);

  lcd_state_t  state;
  logic [31:0] cnt;
  logic        last_grant;
  logic        owner;
  logic [1:0]  grant;
  logic [31:0] wait_last;

  lcd_rr_arb u_arb (
    .req   ({req1, req0}),
    .last  (last_grant),
    .grant (grant)
  );

  // The panel is powered and lit at all times, and the bus only writes.
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;
  assign LCD_RW   = 1'b0;

  // The post-pulse wait uses the RS value latched at grant. Commands need
  // the much longer delay.
  assign wait_last = LCD_RS ? CHAR_LAST : CMD_LAST;

  // Bus sequencer.
  // - The port inputs are sampled only in IDLE, so changes in the middle
  //   of a transfer are ignored.
  // - A transfer runs to completion even if its request is withdrawn.
  // - Reset drops EN immediately and never acks the aborted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      LCD_DATA   <= 8'h00;
      LCD_RS     <= 1'b0;
      LCD_EN     <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            owner      <= grant[1];
            last_grant <= grant[1];
            LCD_DATA   <= grant[1] ? data1 : data0;
            LCD_RS     <= grant[1] ? rs1 : rs0;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt    <= '0;
            LCD_EN <= 1'b1;
            state  <= ST_EN_HIGH;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_EN_HIGH: begin
          if (cnt == PULSE_LAST) begin
            cnt    <= '0;
            LCD_EN <= 1'b0;
            state  <= ST_WAIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_WAIT: begin
          if (cnt == wait_last) begin
            cnt   <= '0;
            ack0  <= ~owner;
            ack1  <= owner;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter
// Scoreboard bench for lcd_bus_arbiter, with RS_SETUP=2, EN_PULSE=4,
// CMD_DELAY=10 and CHAR_DELAY=3. Each issued transfer pushes its expected
// values into a queue: owning port, byte, RS and grant-to-ack latency.
// A monitor process watches the bus. On every ack it pops one entry and
// compares against it.
module tb_lcd_bus_arbiter;

  localparam int TB_RS_SETUP = 2;
  localparam int TB_EN_PULSE = 4;
  localparam int LAT_CMD     = 16;  // 2 + 4 + 10
  localparam int LAT_CHAR    = 9;   // 2 + 4 + 3

  typedef struct {
    bit         port;
    logic [7:0] data;
    bit         rs;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, rs0, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, busy;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  lcd_bus_arbiter #(
    .RS_SETUP   (2),
    .EN_PULSE   (4),
    .CMD_DELAY  (10),
    .CHAR_DELAY (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .rs0      (rs0),
    .rs1      (rs1),
    .data0    (data0),
    .data1    (data1),
    .ack0     (ack0),
    .ack1     (ack1),
    .busy     (busy),
    .LCD_DATA (LCD_DATA),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_ON   (LCD_ON),
    .LCD_BLON (LCD_BLON)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic push_expected(input bit port, input logic [7:0] data,
                               input bit rs, input int lat);
    exp_t e;
    e.port = port;
    e.data = data;
    e.rs   = rs;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit port, input bit rs, input logic [7:0] data);
    if (port) begin
      rs1   = rs;
      data1 = data;
      req1  = 1'b1;
    end else begin
      rs0   = rs;
      data0 = data;
      req0  = 1'b1;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_en(input int max_cycles);
    int n = 0;
    while (!LCD_EN && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_output("en_seen", 32'(LCD_EN), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: tracks the grant, EN edges and acks. It checks each
  // completed transfer against the head of the scoreboard queue.
  initial begin : monitor
    bit         prev_busy;
    bit         prev_en;
    int         g_cyc;
    int         en_rise;
    int         en_fall;
    logic [7:0] g_data;
    logic       g_rs;
    exp_t       e;
    prev_busy = 1'b0;
    prev_en   = 1'b0;
    g_cyc     = -1;
    en_rise   = -1;
    en_fall   = -1;
    g_data    = 8'h00;
    g_rs      = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev_busy = 1'b0;
        prev_en   = 1'b0;
        g_cyc     = -1;
        en_rise   = -1;
        en_fall   = -1;
      end else begin
        if (busy && !prev_busy) begin
          g_cyc   = cyc;
          g_data  = LCD_DATA;
          g_rs    = LCD_RS;
          en_rise = -1;
          en_fall = -1;
        end
        if (LCD_EN && !prev_en) en_rise = cyc;
        if (!LCD_EN && prev_en) en_fall = cyc;
        if (ack0 || ack1) begin
          check_output("ack_exclusive", 32'(ack0 & ack1), 32'd0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_ack actual=ack0:%0b,ack1:%0b required=none",
                     ack0, ack1);
          end else begin
            e = exp_q.pop_front();
            check_output("ack_port",   32'(ack1),       32'(e.port));
            check_output("grant_data", 32'(g_data),     32'(e.data));
            check_output("grant_rs",   32'(g_rs),       32'(e.rs));
            check_output("held_data",  32'(LCD_DATA),   32'(e.data));
            check_output("ack_latency", 32'(cyc - g_cyc), 32'(e.lat));
            check_output("en_delay",   32'(en_rise - g_cyc), 32'(TB_RS_SETUP));
            check_output("en_width",   32'(en_fall - en_rise), 32'(TB_EN_PULSE));
          end
        end
        prev_busy = busy;
        prev_en   = LCD_EN;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    rs0   = 1'b0;
    rs1   = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check_output("rst_lcd_data", 32'(LCD_DATA), 32'h00);
    check_output("rst_lcd_en",   32'(LCD_EN),   32'd0);
    check_output("rst_lcd_rs",   32'(LCD_RS),   32'd0);
    check_output("rst_lcd_rw",   32'(LCD_RW),   32'd0);
    check_output("rst_lcd_on",   32'(LCD_ON),   32'd1);
    check_output("rst_lcd_blon", 32'(LCD_BLON), 32'd1);
    check_output("rst_busy",     32'(busy),     32'd0);
    check_output("rst_acks",     32'({ack1, ack0}), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single command on port 0.
    push_expected(1'b0, 8'h38, 1'b0, LAT_CMD);
    apply_stimulus(1'b0, 1'b0, 8'h38);
    wait_drain(60);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    check_output("idle_hold_data", 32'(LCD_DATA), 32'h38);
    check_output("idle_busy",      32'(busy),     32'd0);

    // Single character on port 1.
    push_expected(1'b1, 8'h41, 1'b1, LAT_CHAR);
    apply_stimulus(1'b1, 1'b1, 8'h41);
    wait_drain(60);
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    check_output("idle_hold_rs", 32'(LCD_RS), 32'd1);

    // Simultaneous requests first after reset: port 0 wins, then they
    // alternate.
    do_reset();
    push_expected(1'b0, 8'h10, 1'b0, LAT_CMD);
    push_expected(1'b1, 8'h20, 1'b1, LAT_CHAR);
    push_expected(1'b0, 8'h10, 1'b0, LAT_CMD);
    push_expected(1'b1, 8'h20, 1'b1, LAT_CHAR);
    apply_stimulus(1'b0, 1'b0, 8'h10);
    apply_stimulus(1'b1, 1'b1, 8'h20);
    wait_drain(200);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) @(negedge clk);

    // Inputs change and the request drops in the middle of the EN pulse.
    push_expected(1'b0, 8'h38, 1'b0, LAT_CMD);
    apply_stimulus(1'b0, 1'b0, 8'h38);
    wait_en(20);
    data0 = 8'hFF;
    rs0   = 1'b1;
    req0  = 1'b0;
    wait_drain(60);
    repeat (3) @(negedge clk);

    // Reset while EN is high: the bus clears at once and no ack follows.
    apply_stimulus(1'b0, 1'b0, 8'h55);
    wait_en(20);
    #2 rst = 1'b0;
    #1;
    check_output("abort_en",   32'(LCD_EN),   32'd0);
    check_output("abort_data", 32'(LCD_DATA), 32'h00);
    check_output("abort_busy", 32'(busy),     32'd0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_output("abort_no_ack_busy", 32'(busy), 32'd0);
    push_expected(1'b1, 8'h41, 1'b1, LAT_CHAR);
    apply_stimulus(1'b1, 1'b1, 8'h41);
    wait_drain(60);
    req1 = 1'b0;
    repeat (5) @(negedge clk);

    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
